// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller for a five-stage RISC-V pipeline: operand forwarding,
// load-use and branch stall/flush, and a memory-wait FSM with timeout and stall counter.
module pipeline_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 MemValidM,
  output logic                 MemErr,
  output logic [CNT_WIDTH-1:0] StallCount
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  state_t                state_reg, state_next;
  logic [WW-1:0]         wait_cnt_reg, wait_cnt_next;
  logic [CNT_WIDTH-1:0]  stall_cnt_reg;
  logic                  mem_stall;
  logic                  load_stall;

  logic [4:0] rs_e [2];
  logic [1:0] fwd  [2];

  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;

  // Memory-stage result is newer than writeback, so it takes precedence.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      fwd[gi] = 2'b00;
      if (RegWriteM && RdM != 5'd0 && RdM == rs_e[gi])
        fwd[gi] = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == rs_e[gi])
        fwd[gi] = 2'b01;
    end
  end

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  assign load_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_stall     = 1'b0;
    case (state_reg)
      RUN: begin
        mem_stall = MemReqM && !MemReadyM;
        if (mem_stall) begin
          state_next    = WAIT;
          wait_cnt_next = WW'(1);
        end else begin
          wait_cnt_next = '0;
        end
      end
      WAIT: begin
        if (MemReadyM || !MemReqM) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_reg == WW'(MEM_TIMEOUT - 1))
            state_next = ERR;
          else
            wait_cnt_next = wait_cnt_reg + WW'(1);
        end
      end
      ERR:     mem_stall = 1'b1;
      default: state_next = RUN;
    endcase
  end

  // A memory stall freezes D and E, so any pending flush is re-evaluated after release.
  always_comb begin
    StallF = load_stall;
    StallD = load_stall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushW = 1'b0;
    FlushD = PCSrcE;
    FlushE = load_stall || PCSrcE;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
    end
  end

  assign MemValidM  = MemReqM && (state_reg != ERR);
  assign MemErr     = (state_reg == ERR);
  assign StallCount = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (StallF && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: table of combinational hazard vectors plus
// hand-written memory miss, timeout, saturation and reset sequences.
module tb_pipeline_controller;

  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemValidM, MemErr;
  logic [CW-1:0] StallCount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemValidM(MemValidM), .MemErr(MemErr), .StallCount(StallCount)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [4:0] rdm, rdw;
    logic       rwm, rww;
    logic [1:0] fa, fb;
    logic       stall, fd, fe;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive memory inputs for one cycle and check stall group / memory outputs mid-cycle.
  task automatic mem_cycle(input string tag, input logic req, input logic rdy, input logic br,
                           input logic exp_stall, input logic exp_valid, input logic exp_err);
    MemReqM = req; MemReadyM = rdy; PCSrcE = br;
    #1;
    $display("%s: req=%0b rdy=%0b br=%0b stallF=%0b stallM=%0b flushW=%0b valid=%0b err=%0b cnt=%0d",
             tag, req, rdy, br, StallF, StallM, FlushW, MemValidM, MemErr, StallCount);
    chk({tag, ".StallF"}, 32'(StallF), 32'(exp_stall));
    chk({tag, ".StallM"}, 32'(StallM), 32'(exp_stall));
    chk({tag, ".FlushW"}, 32'(FlushW), 32'(exp_stall));
    chk({tag, ".MemValidM"}, 32'(MemValidM), 32'(exp_valid));
    chk({tag, ".MemErr"}, 32'(MemErr), 32'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    //             rs1d rs2d rs1e rs2e rde rsrc pc rdm rdw rwm rww  fa fb st fd fe
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'd0, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'd0, 1'b0, 5'd0, 5'd5, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 2'd0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 2'd0, 1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'd1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 2'd0, 1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0};

    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.MemErr", 32'(MemErr), 32'd0);
    chk("reset.StallCount", 32'(StallCount), 32'd0);
    chk("reset.StallF", 32'(StallF), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcsrc;
      RdM = vecs[i].rdm; RdW = vecs[i].rdw; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      #1;
      $display("vec%0d: fa=%0d fb=%0d stallF=%0b flushD=%0b flushE=%0b",
               i, ForwardAE, ForwardBE, StallF, FlushD, FlushE);
      chk($sformatf("vec%0d.ForwardAE", i), 32'(ForwardAE), 32'(vecs[i].fa));
      chk($sformatf("vec%0d.ForwardBE", i), 32'(ForwardBE), 32'(vecs[i].fb));
      chk($sformatf("vec%0d.StallF", i), 32'(StallF), 32'(vecs[i].stall));
      chk($sformatf("vec%0d.StallD", i), 32'(StallD), 32'(vecs[i].stall));
      chk($sformatf("vec%0d.FlushD", i), 32'(FlushD), 32'(vecs[i].fd));
      chk($sformatf("vec%0d.FlushE", i), 32'(FlushE), 32'(vecs[i].fe));
      chk($sformatf("vec%0d.StallE_StallM_FlushW", i), 32'({StallE, StallM, FlushW}), 32'd0);
      @(negedge clk);
    end
    // Two load-use vectors stalled fetch for one cycle each.
    chk("table.StallCount", 32'(StallCount), 32'd2);

    // Three-cycle miss, then back-to-back miss overlapping a taken branch, then a hit.
    do_reset();
    mem_cycle("miss.c1", 1, 0, 0, 1, 1, 0);
    mem_cycle("miss.c2", 1, 0, 0, 1, 1, 0);
    mem_cycle("miss.c3", 1, 0, 0, 1, 1, 0);
    mem_cycle("miss.c4", 1, 1, 0, 0, 1, 0);
    chk("miss.StallCount", 32'(StallCount), 32'd3);
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    #1;
    chk("b2b.StallF", 32'(StallF), 32'd1);
    chk("b2b.FlushD_held", 32'(FlushD), 32'd0);
    chk("b2b.FlushE_held", 32'(FlushE), 32'd0);
    @(negedge clk);
    MemReadyM = 1;
    #1;
    chk("release.StallF", 32'(StallF), 32'd0);
    chk("release.FlushD", 32'(FlushD), 32'd1);
    chk("release.FlushE", 32'(FlushE), 32'd1);
    @(negedge clk);
    mem_cycle("hit", 1, 1, 0, 0, 1, 0);
    mem_cycle("idle", 0, 0, 0, 0, 0, 0);
    chk("hit.StallCount", 32'(StallCount), 32'd4);

    // Timeout with MEM_TIMEOUT=4: four stalled cycles, then ERR ignores MemReadyM.
    do_reset();
    mem_cycle("to.c1", 1, 0, 0, 1, 1, 0);
    mem_cycle("to.c2", 1, 0, 0, 1, 1, 0);
    mem_cycle("to.c3", 1, 0, 0, 1, 1, 0);
    mem_cycle("to.c4", 1, 0, 0, 1, 1, 0);
    mem_cycle("to.c5", 1, 0, 0, 1, 0, 1);
    mem_cycle("to.c6", 1, 1, 0, 1, 0, 1);
    mem_cycle("to.c7", 0, 0, 0, 1, 0, 1);
    mem_cycle("to.c8", 1, 0, 0, 1, 0, 1);
    // Eight stalled cycles on a 3-bit counter saturate at 7.
    chk("to.StallCount_sat", 32'(StallCount), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    MemReqM = 1; MemReadyM = 0;
    #1;
    chk("to.rst.MemErr", 32'(MemErr), 32'd0);
    chk("to.rst.StallCount", 32'(StallCount), 32'd0);
    chk("to.rst.MemValidM", 32'(MemValidM), 32'd1);
    MemReqM = 0;
    #1;
    chk("to.rst.StallF", 32'(StallF), 32'd0);
    chk("to.rst.StallM", 32'(StallM), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Hazard and sequencing controller for the five-stage RISC-V pipeline. Produces register-file forwarding selects, fetch/decode stalls, decode/execute flushes for load-use and taken branches, and a hold for the EX/MEM and downstream registers while a variable-latency data-memory access completes. Contains a memory-wait state machine with timeout and a saturating stall-cycle counter. Sits beside the datapath and drives the enable/flush inputs of every pipeline register.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-stall cycles tolerated before error (≥2)
- CNT_WIDTH, 32: width of StallCount
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  source/destination registers in Execute
- ResultSrcE  in  2  result select in Execute; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- RdM, RdW  in  5  destinations in Memory / Writeback
- RegWriteM, RegWriteW  in  1  register write enables in Memory / Writeback
- MemReqM  in  1  load or store present in Memory stage
- MemReadyM  in  1  data memory completes the access this cycle
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 Writeback result, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- FlushD, FlushE, FlushW  out  1  clear IF/ID, ID/EX, MEM/WB to a bubble
- MemValidM  out  1  request strobe to data memory
- MemErr  out  1  sticky memory-timeout error
- StallCount  out  CNT_WIDTH  saturating count of cycles with StallF=1

## Operation
- Forwarding (combinational): ForwardAE=10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00. ForwardBE identical with Rs2E. Memory stage wins when both match.
- LoadStall = (ResultSrcE==2'b01) & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- FSM states RUN, WAIT, ERR.
  - RUN: MemStall = MemReqM & ~MemReadyM. If MemStall: next WAIT, WaitCnt←1. Else stay, WaitCnt←0.
  - WAIT: MemStall = MemReqM & ~MemReadyM. If MemReadyM or ~MemReqM: MemStall=0, next RUN, WaitCnt←0. Else if WaitCnt==MEM_TIMEOUT-1: next ERR. Else WaitCnt←WaitCnt+1.
  - ERR: MemStall=1 permanently; leaves only on rst.
- Output priority:
  - MemStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (pending branch/load-use is re-evaluated once released, since E/D are held).
  - Else: StallF=StallD=LoadStall; StallE=StallM=FlushW=0; FlushD=PCSrcE; FlushE=LoadStall | PCSrcE.
- MemValidM = MemReqM & (state≠ERR).
- MemErr = (state==ERR), registered.
- StallCount: +1 on every cycle with StallF=1; holds at all-ones.

## Timing
- Reset (rst high at an edge): state←RUN, WaitCnt←0, StallCount←0, MemErr←0. Combinational outputs in the reset cycle are evaluated as state RUN.
- Forwarding, stalls, flushes, MemValidM: zero-latency combinational from inputs and current state.
- Memory hit (MemReadyM=1 in first cycle of MemReqM): no stall.
- Miss: stall from first MemReqM cycle through the cycle before MemReadyM; the MemReadyM cycle itself is unstalled; FSM back in RUN next cycle; a back-to-back miss from the next instruction re-enters WAIT with no idle cycle.
- Timeout: exactly MEM_TIMEOUT consecutive stall cycles without MemReadyM → ERR at the following edge; MemErr high from then; MemReadyM in ERR ignored.
- rst mid-WAIT or in ERR: returns to RUN next cycle, all stalls drop.
- StallCount updated at edge after the stalled cycle.

## Test plan
- Forward: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 → ForwardAE=10, ForwardBE=00; RdM=0 → ForwardAE=01.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, FlushD=0; RdE=0 → no stall.
- Branch: PCSrcE=1 with LoadStall → FlushD=FlushE=1, StallF=StallD=1.
- Miss of 3 cycles (MemReqM=1, MemReadyM high on 4th cycle) → StallF/StallM/FlushW high exactly cycles 1-3, low cycle 4; StallCount=3.
- Timeout with MEM_TIMEOUT=4, MemReadyM stuck 0 → stalls 4 cycles, MemErr=1 on 5th cycle, MemValidM=0, stalls persist; rst → MemErr=0, StallCount=0, stalls clear.
- Miss with concurrent PCSrcE=1 → FlushD=FlushE=0 during stall, FlushD=FlushE=1 in release cycle.
